reg_bank_slave: RTL and testbench

- Register bank at the slave end of the register write channel (reg_wrchan_if.slave).
- Holds K_NREG registers of K_DWIDTH bits. Applies bit-masked writes and exposes register contents to hardware.
- Serves a pipelined read channel with one-cycle latency.
- Sits between the bus-side master (bridge or debug front-end) and peripheral logic.

---
 rtl/reg_bank_pkg.sv | 36 +++
 rtl/reg_wrchan_if.sv | 13 +
 rtl/reg_bank_cell.sv | 50 +++++
 rtl/reg_bank_slave.sv | 107 ++++++++++
 tb/tb_reg_bank_slave.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank: access kinds and address decode.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    RA_RW  = 2'd0,
    RA_RO  = 2'd1,
    RA_W1C = 2'd2
  } reg_access_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] idx;
  } decode_t;

  // Read-only wins when a register is tagged both RO and W1C.
  function automatic reg_access_t f_access(input logic ro_mask_bit, input logic w1c_mask_bit);
    if (ro_mask_bit) begin
      return RA_RO;
    end else if (w1c_mask_bit) begin
      return RA_W1C;
    end
    return RA_RW;
  endfunction

  // Addresses are widened to 32 bits so the subtraction and range check never wrap.
  function automatic decode_t f_decode(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned nreg);
    logic [31:0] diff;
    decode_t     d;
    diff  = addr - base;
    d.hit = (addr >= base) && (diff < nreg);
    d.idx = diff[7:0];
    return d;
  endfunction

endpackage

// File: rtl/reg_wrchan_if.sv
// Register write channel: one transaction per cycle with write asserted, no backpressure.
interface reg_wrchan_if #(
  parameter int K_AWIDTH = 16,
  parameter int K_DWIDTH = 8
);
  logic [K_AWIDTH-1:0] addr;
  logic [K_DWIDTH-1:0] data;
  logic [K_DWIDTH-1:0] bmask;
  logic                write;

  modport master (output addr, output data, output bmask, output write);
  modport slave  (input addr, input data, input bmask, input write);
endinterface

// File: rtl/reg_bank_cell.sv
// One register of the bank; its update rule is fixed at elaboration by K_ACCESS.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int                   K_DWIDTH    = 8,
  parameter reg_access_t          K_ACCESS    = RA_RW,
  parameter logic [K_DWIDTH-1:0]  K_RESET_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [K_DWIDTH-1:0] i_data,
  input  logic [K_DWIDTH-1:0] i_bmask,
  input  logic [K_DWIDTH-1:0] i_hw_val,
  input  logic [K_DWIDTH-1:0] i_hw_set,
  output logic [K_DWIDTH-1:0] o_value
);

  logic [K_DWIDTH-1:0] r_value;
  logic                w_unused;

  // Not every access kind consumes every input.
  assign w_unused = ^{i_we, i_data, i_bmask, i_hw_val, i_hw_set};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= K_RESET_VAL;
    end else begin
      case (K_ACCESS)
        RA_RO: r_value <= i_hw_val;
        // Hardware set is OR-ed last so it beats a software clear on the same bit.
        RA_W1C: begin
          if (i_we) begin
            r_value <= (r_value & ~(i_data & i_bmask)) | i_hw_set;
          end else begin
            r_value <= r_value | i_hw_set;
          end
        end
        default: begin
          if (i_we) begin
            r_value <= (r_value & ~i_bmask) | (i_data & i_bmask);
          end
        end
      endcase
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/reg_bank_slave.sv
// Register bank slave: masked writes from the write channel, one-cycle read pipeline,
// and per-register strobes and error pulses back to the bus side.
module reg_bank_slave
  import reg_bank_pkg::*;
#(
  parameter int                            K_DWIDTH    = 8,
  parameter int                            K_AWIDTH    = 16,
  parameter int                            K_NREG      = 16,
  parameter logic [K_AWIDTH-1:0]           K_BASE      = '0,
  parameter logic [K_NREG-1:0]             K_RO_MASK   = '0,
  parameter logic [K_NREG-1:0]             K_W1C_MASK  = '0,
  parameter logic [K_NREG*K_DWIDTH-1:0]    K_RESET_VAL = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  reg_wrchan_if.slave                  wr,
  input  logic                         i_rd_req,
  input  logic [K_AWIDTH-1:0]          i_rd_addr,
  output logic                         o_rd_valid,
  output logic [K_DWIDTH-1:0]          o_rd_data,
  output logic                         o_rd_err,
  output logic                         o_wr_err,
  output logic [K_NREG-1:0]            o_wr_strobe,
  output logic [K_NREG*K_DWIDTH-1:0]   o_regs,
  input  logic [K_NREG*K_DWIDTH-1:0]   i_hw_val,
  input  logic [K_NREG*K_DWIDTH-1:0]   i_hw_set
);

  decode_t             w_wr_dec;
  decode_t             w_rd_dec;
  logic [K_NREG-1:0]   w_wr_sel;
  logic [K_NREG-1:0]   w_we;
  logic                w_wr_err;
  logic [K_DWIDTH-1:0] w_regs [K_NREG];
  logic [K_DWIDTH-1:0] w_rd_mux;

  logic                r_rd_vld_p1;
  logic [K_DWIDTH-1:0] r_rd_data_p1;
  logic                r_rd_err_p1;
  logic                r_wr_err_p1;
  logic [K_NREG-1:0]   r_wr_strobe_p1;

  assign w_wr_dec = f_decode(32'(wr.addr), 32'(K_BASE), K_NREG);
  assign w_rd_dec = f_decode(32'(i_rd_addr), 32'(K_BASE), K_NREG);

  for (genvar gi = 0; gi < K_NREG; gi++) begin : g_reg
    localparam reg_access_t L_ACC = f_access(K_RO_MASK[gi], K_W1C_MASK[gi]);

    // Gating on write keeps undriven address/data from reaching the cells.
    assign w_wr_sel[gi] = wr.write && w_wr_dec.hit && (w_wr_dec.idx == 8'(gi));
    assign w_we[gi]     = w_wr_sel[gi] && (L_ACC != RA_RO);

    reg_bank_cell #(
      .K_DWIDTH   (K_DWIDTH),
      .K_ACCESS   (L_ACC),
      .K_RESET_VAL(K_RESET_VAL[gi*K_DWIDTH +: K_DWIDTH])
    ) u_cell (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_we[gi]),
      .i_data  (wr.data),
      .i_bmask (wr.bmask),
      .i_hw_val(i_hw_val[gi*K_DWIDTH +: K_DWIDTH]),
      .i_hw_set(i_hw_set[gi*K_DWIDTH +: K_DWIDTH]),
      .o_value (w_regs[gi])
    );

    assign o_regs[gi*K_DWIDTH +: K_DWIDTH] = w_regs[gi];
  end

  // Misses and RO targets both leave w_we empty.
  assign w_wr_err = wr.write && (w_we == '0);

  // Stage p0: read mux sees register state before this cycle's write lands.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < K_NREG; i++) begin
      if (w_rd_dec.hit && (w_rd_dec.idx == 8'(i))) begin
        w_rd_mux = w_regs[i];
      end
    end
  end

  // Stage p1: registered responses, strobes and error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld_p1    <= 1'b0;
      r_rd_data_p1   <= '0;
      r_rd_err_p1    <= 1'b0;
      r_wr_err_p1    <= 1'b0;
      r_wr_strobe_p1 <= '0;
    end else begin
      r_rd_vld_p1    <= i_rd_req;
      r_rd_data_p1   <= i_rd_req ? w_rd_mux : '0;
      r_rd_err_p1    <= i_rd_req && !w_rd_dec.hit;
      r_wr_err_p1    <= w_wr_err;
      r_wr_strobe_p1 <= w_we;
    end
  end

  assign o_rd_valid  = r_rd_vld_p1;
  assign o_rd_data   = r_rd_data_p1;
  assign o_rd_err    = r_rd_err_p1;
  assign o_wr_err    = r_wr_err_p1;
  assign o_wr_strobe = r_wr_strobe_p1;

endmodule

// File: tb/tb_reg_bank_slave.sv
// Directed bench for reg_bank_slave: reset, masked writes, W1C races, errors and read timing.
module tb_reg_bank_slave;

  localparam int              DW   = 8;
  localparam int              AW   = 16;
  localparam int              NREG = 16;
  localparam logic [AW-1:0]   BASE = 16'h0010;
  localparam logic [NREG-1:0] RO   = 16'h0020;
  localparam logic [NREG-1:0] W1C  = 16'h0008;
  localparam logic [NREG*DW-1:0] RV = {80'h0, 8'h5A, 8'h00, 8'h81, 8'hA5, 8'h11, 8'h00};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_valid;
  logic [DW-1:0]        rd_data;
  logic                 rd_err;
  logic                 wr_err;
  logic [NREG-1:0]      wr_strobe;
  logic [NREG*DW-1:0]   regs;
  logic [NREG*DW-1:0]   hw_val;
  logic [NREG*DW-1:0]   hw_set;

  int n_checks = 0;
  int n_fail   = 0;

  reg_wrchan_if #(.K_AWIDTH(AW), .K_DWIDTH(DW)) u_wr ();

  reg_bank_slave #(
    .K_DWIDTH   (DW),
    .K_AWIDTH   (AW),
    .K_NREG     (NREG),
    .K_BASE     (BASE),
    .K_RO_MASK  (RO),
    .K_W1C_MASK (W1C),
    .K_RESET_VAL(RV)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .wr         (u_wr.slave),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_rd_err   (rd_err),
    .o_wr_err   (wr_err),
    .o_wr_strobe(wr_strobe),
    .o_regs     (regs),
    .i_hw_val   (hw_val),
    .i_hw_set   (hw_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return regs[i*DW +: DW];
  endfunction

  task automatic wr_set(input int idx, input logic [DW-1:0] d, input logic [DW-1:0] m);
    u_wr.write = 1'b1;
    u_wr.addr  = 16'(BASE + 16'(idx));
    u_wr.data  = d;
    u_wr.bmask = m;
  endtask

  task automatic wr_idle();
    u_wr.write = 1'b0;
    u_wr.addr  = 'x;
    u_wr.data  = 'x;
    u_wr.bmask = 'x;
  endtask

  task automatic rd_set(input int idx);
    rd_req  = 1'b1;
    rd_addr = 16'(BASE + 16'(idx));
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    hw_val  = '0;
    hw_val[5*DW +: DW] = 8'h3C;
    hw_set  = '0;
    wr_idle();

    #12;
    chk("reset_regs", 128'(regs), 128'(RV));
    chk("reset_rd_valid", 128'(rd_valid), 128'(0));
    chk("reset_wr_err", 128'(wr_err), 128'(0));
    chk("reset_strobe", 128'(wr_strobe), 128'(0));
    rst_n = 1'b1;

    step();
    chk("ro_hw_load", 128'(reg_of(5)), 128'(8'h3C));
    chk("idle_rd_valid", 128'(rd_valid), 128'(0));

    rd_set(2);
    step();
    rd_req = 1'b0;
    chk("rd_reg2_valid", 128'(rd_valid), 128'(1));
    chk("rd_reg2_data", 128'(rd_data), 128'(8'hA5));
    chk("rd_reg2_err", 128'(rd_err), 128'(0));

    wr_set(0, 8'hFF, 8'h0F);
    step();
    wr_idle();
    chk("mask_wr_reg0", 128'(reg_of(0)), 128'(8'h0F));
    chk("mask_wr_strobe", 128'(wr_strobe), 128'(16'h0001));
    chk("mask_wr_err", 128'(wr_err), 128'(0));
    step();
    chk("strobe_once", 128'(wr_strobe), 128'(0));
    chk("idle_rd_data", 128'(rd_data), 128'(0));

    rd_set(0);
    step();
    rd_req = 1'b0;
    chk("rd_reg0_data", 128'(rd_data), 128'(8'h0F));

    wr_set(3, 8'h81, 8'hFF);
    hw_set[3*DW +: DW] = 8'h01;
    step();
    wr_idle();
    hw_set = '0;
    chk("w1c_race", 128'(reg_of(3)), 128'(8'h01));
    chk("w1c_strobe", 128'(wr_strobe), 128'(16'h0008));

    hw_set[3*DW +: DW] = 8'h40;
    hw_set[0*DW +: DW] = 8'h80;
    step();
    hw_set = '0;
    chk("w1c_hw_set", 128'(reg_of(3)), 128'(8'h41));
    chk("rw_ignores_set", 128'(reg_of(0)), 128'(8'h0F));

    wr_set(5, 8'hFF, 8'hFF);
    step();
    wr_idle();
    chk("ro_wr_err", 128'(wr_err), 128'(1));
    chk("ro_wr_strobe", 128'(wr_strobe), 128'(0));
    chk("ro_unchanged", 128'(reg_of(5)), 128'(8'h3C));
    step();
    chk("wr_err_pulse", 128'(wr_err), 128'(0));

    wr_set(NREG, 8'hFF, 8'hFF);
    step();
    wr_idle();
    chk("miss_hi_wr_err", 128'(wr_err), 128'(1));
    chk("miss_hi_strobe", 128'(wr_strobe), 128'(0));

    u_wr.write = 1'b1;
    u_wr.addr  = 16'(BASE - 16'd1);
    u_wr.data  = 8'hFF;
    u_wr.bmask = 8'hFF;
    step();
    wr_idle();
    chk("miss_lo_wr_err", 128'(wr_err), 128'(1));
    chk("miss_lo_reg15", 128'(reg_of(15)), 128'(0));

    rd_set(NREG);
    step();
    rd_req = 1'b0;
    chk("rd_miss_valid", 128'(rd_valid), 128'(1));
    chk("rd_miss_err", 128'(rd_err), 128'(1));
    chk("rd_miss_data", 128'(rd_data), 128'(0));

    rd_set(1);
    wr_set(1, 8'h22, 8'hFF);
    step();
    wr_idle();
    chk("rbw_old_data", 128'(rd_data), 128'(8'h11));
    chk("rbw_reg1", 128'(reg_of(1)), 128'(8'h22));
    step();
    chk("rbw_new_data", 128'(rd_data), 128'(8'h22));

    rd_set(0);
    step();
    chk("b2b_0", 128'({rd_valid, rd_data}), 128'({1'b1, 8'h0F}));
    rd_set(1);
    step();
    chk("b2b_1", 128'({rd_valid, rd_data}), 128'({1'b1, 8'h22}));
    rd_set(2);
    step();
    chk("b2b_2", 128'({rd_valid, rd_data}), 128'({1'b1, 8'hA5}));
    rd_set(3);
    step();
    rd_req = 1'b0;
    chk("b2b_3", 128'({rd_valid, rd_data}), 128'({1'b1, 8'h41}));
    step();
    chk("b2b_end", 128'({rd_valid, rd_err, rd_data}), 128'(0));

    wr_set(4, 8'hFF, 8'h00);
    step();
    wr_idle();
    chk("zero_mask_strobe", 128'(wr_strobe), 128'(16'h0010));
    chk("zero_mask_reg4", 128'(reg_of(4)), 128'(0));

    rd_set(2);
    step();
    rd_req = 1'b0;
    chk("pre_rst_valid", 128'(rd_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(rd_valid), 128'(0));
    chk("async_rst_data", 128'(rd_data), 128'(0));
    chk("async_rst_regs", 128'(regs), 128'(RV));

    @(negedge clk);
    rst_n = 1'b1;
    rd_set(1);
    #2 rst_n = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("rst_pending_valid", 128'(rd_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 128'(rd_valid), 128'(0));
    chk("post_rst_reg1", 128'(reg_of(1)), 128'(8'h11));
    chk("post_rst_ro", 128'(reg_of(5)), 128'(8'h3C));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
